// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, parity codes and baud divisor helper.
//   uart_tx_state_t  transmitter FSM states
//   PAR_*            parity mode codes
//   baud_div()       integer clock divisor, truncated
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD = 1;
  localparam int PAR_EVEN = 2;
  function automatic int baud_div(input longint clk_hz, input longint baud);
    return int'(clk_hz / baud);
  endfunction
endpackage

// File: rtl/uart_tx_stream_if.sv
// uart_tx_stream_if: byte-stream valid/ready handshake.
//   s_data   word from source
//   s_valid  source has a word
//   s_ready  sink can accept; accept = s_valid & s_ready at clk edge
interface uart_tx_stream_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] s_data;
  logic s_valid;
  logic s_ready;
  modport master(output s_data, s_valid, input s_ready);
  modport slave(input s_data, s_valid, output s_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: divide-by-DIV counter with sync clear and wrap tick.
//   clk, rst  clock, async active-high reset
//   clr       restart the count at 0 on the next edge
//   cnt       current position within the bit, 0..DIV-1
//   tick      high during the last clock of each bit (cnt == DIV-1)
module uart_baud_gen #(
  parameter int DIV = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  output logic [$clog2(DIV)-1:0] cnt,
  output logic                   tick
);
  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] TOP = W'(DIV - 1);
  assign tick = cnt == TOP;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx_stream.sv
// uart_tx_stream: UART transmitter fed by a valid/ready byte stream.
//   clk, rst  clock, async active-high reset
//   s         stream slave: s_data, s_valid in; s_ready out (high exactly in IDLE)
//   tx        serial line, idle high
//   busy      frame in progress
//   tx_done   1-cycle pulse in the last clock of the final stop bit
module uart_tx_stream import uart_pkg::*; #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  uart_tx_stream_if.slave         s,
  output logic                    tx,
  output logic                    busy,
  output logic                    tx_done
);
  localparam int DIV = baud_div(CLK_FREQ_HZ, BAUD_RATE);
  localparam int BW = $clog2(DIV);
  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] PRE_LAST = BW'(DIV - 2);
  localparam logic [CW-1:0] LAST_D = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] LAST_S = CW'(STOP_BITS - 1);
  localparam bit HAS_PAR = PARITY != PAR_NONE;
  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_stream: clock divisor must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
    $error("uart_tx_stream: DATA_BITS must be 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_par
    $error("uart_tx_stream: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_stream: STOP_BITS must be 1 or 2");
  end
  uart_tx_state_t state;
  logic [DATA_BITS-1:0] shift;
  logic par;
  logic [CW-1:0] bit_cnt;
  logic [BW-1:0] baud_cnt;
  logic tick;
  // Holding the counter clear through IDLE aligns every frame to the accept edge.
  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == IDLE),
    .cnt  (baud_cnt),
    .tick (tick)
  );
  // tx is registered, so each bit value is loaded on the edge that ends the previous bit.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      shift <= '0;
      par <= 1'b0;
      bit_cnt <= '0;
      tx <= 1'b1;
      s.s_ready <= 1'b1;
      busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      // Registered pulse: raised one clock early so it lands in the final stop clock.
      tx_done <= state == STOP && bit_cnt == LAST_S && baud_cnt == PRE_LAST;
      case (state)
        IDLE:
          if (s.s_valid) begin
            state <= START;
            shift <= s.s_data;
            par <= (PARITY == PAR_ODD) ? ~^s.s_data : ^s.s_data;
            bit_cnt <= '0;
            tx <= 1'b0;
            s.s_ready <= 1'b0;
            busy <= 1'b1;
          end
        START:
          if (tick) begin
            state <= DATA;
            tx <= shift[0];
            shift <= shift >> 1;
          end
        DATA:
          if (tick) begin
            if (bit_cnt == LAST_D) begin
              state <= HAS_PAR ? uart_pkg::PARITY : STOP;
              tx <= HAS_PAR ? par : 1'b1;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx <= shift[0];
              shift <= shift >> 1;
            end
          end
        uart_pkg::PARITY:
          if (tick) begin
            state <= STOP;
            tx <= 1'b1;
          end
        STOP:
          if (tick) begin
            if (bit_cnt == LAST_S) begin
              state <= IDLE;
              s.s_ready <= 1'b1;
              busy <= 1'b0;
            end else bit_cnt <= bit_cnt + 1'b1;
          end
        default: begin
          state <= IDLE;
          tx <= 1'b1;
          s.s_ready <= 1'b1;
          busy <= 1'b0;
        end
      endcase
    end
endmodule
